// File: rtl/serial_alu_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer and its integration wrappers.
// State encodings are fixed so that debug probes and wrappers can decode them.
package serial_alu_defs;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] ALU_OP_ADD = 3'b011;

endpackage

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer around a 1-bit ALU slice: feeds LSB-first bit pairs,
// chains the slice carry and assembles the result and flags under start/ready/done.
module serial_alu_seq
    import serial_alu_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic [2:0]       alu_s,
    input  logic             alu_out,
    input  logic             alu_cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
    logic [2:0]       op_q;
    logic             carry_q;
    logic [CW-1:0]    count;
    logic             last;

    assign last    = (state == S_RUN) && (count == CW'(WIDTH - 1));
    assign res_nxt = {alu_out, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        alu_a     = 1'b0;
        alu_b     = 1'b0;
        alu_cin   = 1'b0;
        alu_s     = op_q;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy    = 1'b1;
                alu_a   = a_sh[0];
                alu_b   = b_sh[0];
                alu_cin = carry_q;
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                ready     = 1'b1;
                done      = 1'b1;
                state_nxt = start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bits accumulate in res_sh so the visible result only changes on completion;
    // on the last step carry_q still holds the carry into the MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            count    <= '0;
            result   <= '0;
            carryout <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else if (start && ready) begin
            a_sh    <= a;
            b_sh    <= b;
            op_q    <= op;
            carry_q <= carry_in;
            count   <= '0;
            res_sh  <= '0;
        end else if (state == S_RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            res_sh  <= res_nxt;
            carry_q <= alu_cout;
            count   <= count + CW'(1);
            if (last) begin
                result   <= res_nxt;
                carryout <= alu_cout;
                overflow <= carry_q ^ alu_cout;
                zero     <= (res_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Scoreboard bench for serial_alu_seq with a behavioural 1-bit slice (ADD/AND).
module tb_serial_alu_seq;
    import serial_alu_defs::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, start, carry_in;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         ready, busy, done, carryout, zero, overflow;
    logic [W-1:0] result;
    logic         alu_a, alu_b, alu_cin, alu_out, alu_cout;
    logic [2:0]   alu_s;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         z;
        logic         ov;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slice model: ADD with ripple carry, AND with no carry, anything else zero.
    assign alu_out  = (alu_s == ALU_OP_ADD) ? (alu_a ^ alu_b ^ alu_cin) :
                      (alu_s == 3'b000)     ? (alu_a & alu_b) : 1'b0;
    assign alu_cout = (alu_s == ALU_OP_ADD) ?
                      ((alu_a & alu_b) | (alu_cin & (alu_a ^ alu_b))) : 1'b0;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .carry_in(carry_in),
        .a(a), .b(b), .ready(ready), .busy(busy), .done(done), .result(result),
        .carryout(carryout), .zero(zero), .overflow(overflow),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_s(alu_s),
        .alu_out(alu_out), .alu_cout(alu_cout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ta, tb, input logic [2:0] top,
                                   input logic tcin);
        exp_t e;
        logic [W:0]   s;
        logic [W-1:0] lo;
        e.cyc = 0;
        if (top == ALU_OP_ADD) begin
            s    = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tcin};
            lo   = {1'b0, ta[W-2:0]} + {1'b0, tb[W-2:0]} + {{(W-1){1'b0}}, tcin};
            e.res = s[W-1:0];
            e.co  = s[W];
            e.ov  = lo[W-1] ^ s[W];
        end else begin
            e.res = (top == 3'b000) ? (ta & tb) : '0;
            e.co  = 1'b0;
            e.ov  = tcin;
        end
        e.z = (e.res == '0);
        return e;
    endfunction

    // Drive one start at the next edge and queue its expected outcome.
    task automatic go(input logic [W-1:0] ta, tb, input logic [2:0] top, input logic tcin);
        exp_t e;
        @(negedge clk);
        a = ta; b = tb; op = top; carry_in = tcin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e = model(ta, tb, top, tcin);
        e.cyc = cyc + W;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        chk("drain", sb.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("carryout", carryout, e.co);
                chk("zero", zero, e.z);
                chk("overflow", overflow, e.ov);
                chk("done_cycle", cyc, e.cyc);
                chk("done_ready", ready, 1);
                chk("done_busy", busy, 0);
            end
        end
    end

    initial begin
        logic [W-1:0] sa, sbv;
        reset = 1'b1; start = 1'b0; op = ALU_OP_ADD; carry_in = 1'b0; a = '0; b = '0;
        #1;
        chk("rst_result", result, 0);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {carryout, zero, overflow}, 0);
        chk("rst_drive", {alu_a, alu_b, alu_cin}, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        go(8'h05, 8'h03, ALU_OP_ADD, 1'b0); drain();
        go(8'hFF, 8'h01, ALU_OP_ADD, 1'b0); drain();
        go(8'h7F, 8'h01, ALU_OP_ADD, 1'b0); drain();
        go(8'h80, 8'h80, ALU_OP_ADD, 1'b0); drain();
        go(8'hF0, 8'h3C, 3'b000, 1'b0);     drain();
        go(8'h0F, 8'hF0, ALU_OP_ADD, 1'b1); drain();

        // Start during RUN must be ignored; also watch the serial feed bit by bit.
        sa = 8'h12; sbv = 8'h34;
        go(sa, sbv, ALU_OP_ADD, 1'b0);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("run_ready", ready, 0);
            chk("run_busy", busy, 1);
            chk("run_alu_a", alu_a, sa[i]);
            chk("run_alu_b", alu_b, sbv[i]);
            chk("run_alu_s", alu_s, ALU_OP_ADD);
            if (i == 2) begin a = 8'hAA; start = 1'b1; end
            if (i == 3) start = 1'b0;
        end
        drain();

        // Asynchronous reset mid-RUN: immediate return to reset values, no done.
        go(8'h21, 8'h43, ALU_OP_ADD, 1'b0);
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_result", result, 0);
        chk("arst_ready", ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_flags", {carryout, zero, overflow}, 0);
        sb.delete();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        go(8'h10, 8'h20, ALU_OP_ADD, 1'b0); drain();

        // start held through DONE: second operation with no IDLE cycle between.
        begin
            exp_t e;
            @(negedge clk);
            a = 8'h11; b = 8'h22; op = ALU_OP_ADD; carry_in = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            e = model(8'h11, 8'h22, ALU_OP_ADD, 1'b0);
            e.cyc = cyc + W;
            sb.push_back(e);
            a = 8'hC0; b = 8'h50;
            repeat (W) @(posedge clk);
            @(posedge clk); #1;
            start = 1'b0;
            e = model(8'hC0, 8'h50, ALU_OP_ADD, 1'b0);
            e.cyc = cyc + W;
            sb.push_back(e);
            drain();
        end

        for (int k = 0; k < 4; k++) begin
            go(W'($urandom), W'($urandom), ALU_OP_ADD, 1'($urandom_range(1)));
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
